// File: rtl/strait_pkg.sv
// Shared types for the STRAIT self-test scheduler: FSM state codes,
// final status codes and small state-classification helpers.
package strait_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        MBIST_START = 3'd1,
        MBIST_WAIT  = 3'd2,
        LBIST_START = 3'd3,
        LBIST_WAIT  = 3'd4,
        REPAIR_WAIT = 3'd5,
        FINISH      = 3'd6
    } sched_state_t;

    localparam logic [2:0] ST_PASS         = 3'd0;
    localparam logic [2:0] ST_UNREPAIRABLE = 3'd1;
    localparam logic [2:0] ST_MBIST_FAIL   = 3'd2;
    localparam logic [2:0] ST_TIMEOUT      = 3'd3;
    localparam logic [2:0] ST_NONE         = 3'd7;

    function automatic logic is_wait_state(sched_state_t s);
        return (s == MBIST_WAIT) || (s == LBIST_WAIT) || (s == REPAIR_WAIT);
    endfunction

    function automatic logic is_start_state(sched_state_t s);
        return (s == MBIST_START) || (s == LBIST_START);
    endfunction

    // The core stays in test mode for the whole run except the FINISH cycle.
    function automatic logic is_test_state(sched_state_t s);
        return (s != IDLE) && (s != FINISH);
    endfunction

    function automatic logic is_lbist_state(sched_state_t s);
        return (s == LBIST_START) || (s == LBIST_WAIT) || (s == REPAIR_WAIT);
    endfunction

endpackage

// File: rtl/strait_selftest_scheduler_if.sv
// Request, core-handshake and status bundle between the scheduler
// (master) and the STRAIT core / firmware side (slave).
interface strait_selftest_scheduler_if;

    logic       selftest_req;
    logic       skip_mbist;
    logic       bist_start;
    logic       test_mode;
    logic       BIST_mode;
    logic       test_done;
    logic       MBIST_FAIL;
    logic       TD_error_flag;
    logic       recovery_done;
    logic       recovery_success;
    logic       busy;
    logic       done;
    logic [2:0] status;
    logic       td_error_seen;
    logic [2:0] phase;

    modport master (
        input  selftest_req, skip_mbist, test_done, MBIST_FAIL,
               TD_error_flag, recovery_done, recovery_success,
        output bist_start, test_mode, BIST_mode, busy, done, status,
               td_error_seen, phase
    );

    modport slave (
        output selftest_req, skip_mbist, test_done, MBIST_FAIL,
               TD_error_flag, recovery_done, recovery_success,
        input  bist_start, test_mode, BIST_mode, busy, done, status,
               td_error_seen, phase
    );

endinterface

// File: rtl/strait_phase_timer.sv
// Per-phase watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYCLES-1.
module strait_phase_timer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_WIDTH-1:0] count;

    assign expired = (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Saturate at the expiry value so a stalled phase cannot wrap around.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/strait_selftest_scheduler.sv
// Self-test sequencer for the STRAIT core: MBIST, LBIST (SA then TD) and
// BISR recovery, each wait phase guarded by a watchdog.
module strait_selftest_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic                         clk,
    input logic                         rst,
    strait_selftest_scheduler_if.master sif
);

    import strait_pkg::*;

    sched_state_t state;
    sched_state_t nxt;
    logic [2:0]   nxt_status;
    logic         accept;
    logic         sa_done;
    logic         first_td;
    logic         wd_clear;
    logic         wd_enable;
    logic         wd_expired;

    // Completion events always take priority over watchdog expiry.
    always_comb begin
        nxt        = state;
        nxt_status = ST_NONE;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (sif.selftest_req) begin
                    accept = 1'b1;
                    if (sif.skip_mbist) nxt = LBIST_START;
                    else                nxt = MBIST_START;
                end
            end
            MBIST_START: nxt = MBIST_WAIT;
            MBIST_WAIT: begin
                if (sif.test_done) begin
                    if (sif.MBIST_FAIL) begin
                        nxt        = FINISH;
                        nxt_status = ST_MBIST_FAIL;
                    end else begin
                        nxt = LBIST_START;
                    end
                end else if (wd_expired) begin
                    nxt        = FINISH;
                    nxt_status = ST_TIMEOUT;
                end
            end
            LBIST_START: nxt = LBIST_WAIT;
            LBIST_WAIT: begin
                if (sif.test_done) begin
                    if (sa_done) nxt = REPAIR_WAIT;
                end else if (wd_expired) begin
                    nxt        = FINISH;
                    nxt_status = ST_TIMEOUT;
                end
            end
            REPAIR_WAIT: begin
                if (sif.recovery_done) begin
                    nxt        = FINISH;
                    nxt_status = sif.recovery_success ? ST_PASS : ST_UNREPAIRABLE;
                end else if (wd_expired) begin
                    nxt        = FINISH;
                    nxt_status = ST_TIMEOUT;
                end
            end
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The SA-complete pulse restarts the watchdog so TD gets a full budget.
    assign first_td  = (state == LBIST_WAIT) && sif.test_done && !sa_done;
    assign wd_enable = is_wait_state(state);
    assign wd_clear  = (nxt != state) || !wd_enable || first_td;

    strait_phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            sa_done           <= 1'b0;
            sif.phase         <= 3'd0;
            sif.bist_start    <= 1'b0;
            sif.test_mode     <= 1'b0;
            sif.BIST_mode     <= 1'b0;
            sif.busy          <= 1'b0;
            sif.done          <= 1'b0;
            sif.status        <= ST_NONE;
            sif.td_error_seen <= 1'b0;
        end else begin
            state          <= nxt;
            sif.phase      <= nxt;
            sif.bist_start <= is_start_state(nxt);
            sif.test_mode  <= is_test_state(nxt);
            sif.BIST_mode  <= is_lbist_state(nxt);
            sif.busy       <= (nxt != IDLE);
            sif.done       <= (nxt == FINISH);

            if (accept) begin
                sif.status <= ST_NONE;
            end else if ((nxt == FINISH) && (state != FINISH)) begin
                sif.status <= nxt_status;
            end

            if (accept) begin
                sif.td_error_seen <= 1'b0;
            end else if ((state == LBIST_WAIT) && sif.TD_error_flag) begin
                sif.td_error_seen <= 1'b1;
            end

            if (state == LBIST_START) begin
                sa_done <= 1'b0;
            end else if ((state == LBIST_WAIT) && sif.test_done) begin
                sa_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_strait_selftest_scheduler.sv
// Self-checking bench for strait_selftest_scheduler: hand-written corner
// sequences plus a table of full runs checked through a result scoreboard.
module tb_strait_selftest_scheduler;

    import strait_pkg::*;

    localparam int TO = 16;

    typedef struct {
        logic       skip;
        logic       mbist_fail;
        logic       td_err;
        logic       rec_ok;
        logic [2:0] exp_status;
        logic       exp_td;
        int         exp_starts;
    } vec_t;

    typedef struct {
        logic [2:0] status;
        logic       td;
        int         starts;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   start_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[5];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    strait_selftest_scheduler_if sif();

    strait_selftest_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .sif(sif)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            start_cnt = 0;
        end else begin
            if (sif.bist_start) start_cnt++;
            if (sif.done) begin
                checkOutput("done_queue", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("status", int'(sif.status), int'(e.status));
                    checkOutput("td_error_seen", int'(sif.td_error_seen), int'(e.td));
                    checkOutput("bist_start_count", start_cnt, e.starts);
                end
                start_cnt = 0;
            end
        end
    end

    task automatic waitPhase(input sched_state_t target, input string name);
        int n = 0;
        while (sif.phase != target && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(sif.phase), int'(target));
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!sif.done && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(sif.done), 1);
    endtask

    task automatic pulseReq(input logic skip);
        sif.selftest_req = 1'b1;
        sif.skip_mbist   = skip;
        @(negedge clk);
        sif.selftest_req = 1'b0;
        sif.skip_mbist   = 1'b0;
    endtask

    task automatic pulseTestDone(input logic mf);
        sif.test_done  = 1'b1;
        sif.MBIST_FAIL = mf;
        @(negedge clk);
        sif.test_done  = 1'b0;
        sif.MBIST_FAIL = 1'b0;
    endtask

    task automatic pulseRecovery(input logic ok);
        sif.recovery_done    = 1'b1;
        sif.recovery_success = ok;
        @(negedge clk);
        sif.recovery_done    = 1'b0;
        sif.recovery_success = 1'b0;
    endtask

    task automatic pulseTd();
        sif.TD_error_flag = 1'b1;
        @(negedge clk);
        sif.TD_error_flag = 1'b0;
    endtask

    // Plays the core's side of one full run for a table vector.
    task automatic applyStimulus(input vec_t v);
        exp_q.push_back('{v.exp_status, v.exp_td, v.exp_starts});
        pulseReq(v.skip);
        if (!v.skip) begin
            waitPhase(MBIST_WAIT, "reach_mbist_wait");
            repeat (3) @(negedge clk);
            pulseTestDone(v.mbist_fail);
        end
        if (!v.mbist_fail) begin
            waitPhase(LBIST_WAIT, "reach_lbist_wait");
            repeat (2) @(negedge clk);
            pulseTestDone(1'b0);
            if (v.td_err) pulseTd();
            repeat (2) @(negedge clk);
            pulseTestDone(1'b0);
            waitPhase(REPAIR_WAIT, "reach_repair_wait");
            repeat (2) @(negedge clk);
            pulseRecovery(v.rec_ok);
        end
        waitDone("run_done");
        @(negedge clk);
        checkOutput("busy_after_finish", int'(sif.busy), 0);
        checkOutput("test_mode_after_finish", int'(sif.test_mode), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int e;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, ST_PASS,         1'b0, 2};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_MBIST_FAIL,   1'b0, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_UNREPAIRABLE, 1'b1, 2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, ST_PASS,         1'b0, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, ST_PASS,         1'b1, 1};

        sif.selftest_req     = 1'b0;
        sif.skip_mbist       = 1'b0;
        sif.test_done        = 1'b0;
        sif.MBIST_FAIL       = 1'b0;
        sif.TD_error_flag    = 1'b0;
        sif.recovery_done    = 1'b0;
        sif.recovery_success = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(sif.busy), 0);
        checkOutput("rst_done", int'(sif.done), 0);
        checkOutput("rst_bist_start", int'(sif.bist_start), 0);
        checkOutput("rst_test_mode", int'(sif.test_mode), 0);
        checkOutput("rst_BIST_mode", int'(sif.BIST_mode), 0);
        checkOutput("rst_td_seen", int'(sif.td_error_seen), 0);
        checkOutput("rst_status", int'(sif.status), 7);
        checkOutput("rst_phase", int'(sif.phase), 0);
        rst = 1'b0;
        while (cycle < 10) @(negedge clk);

        // Happy path with latency checks and ignored-event corner cases.
        $display("[TB] happy path with robustness checks");
        exp_q.push_back('{ST_PASS, 1'b0, 2});
        checkOutput("busy_before_req", int'(sif.busy), 0);
        sif.selftest_req = 1'b1;
        @(negedge clk);
        sif.selftest_req = 1'b0;
        checkOutput("req_bist_start", int'(sif.bist_start), 1);
        checkOutput("req_busy", int'(sif.busy), 1);
        checkOutput("req_test_mode", int'(sif.test_mode), 1);
        checkOutput("req_BIST_mode", int'(sif.BIST_mode), 0);
        pulseTestDone(1'b1);
        checkOutput("start_ignores_test_done", int'(sif.phase), int'(MBIST_WAIT));
        checkOutput("bist_start_one_cycle", int'(sif.bist_start), 0);
        pulseReq(1'b1);
        checkOutput("busy_req_dropped", int'(sif.phase), int'(MBIST_WAIT));
        pulseRecovery(1'b0);
        checkOutput("recovery_outside_ignored", int'(sif.phase), int'(MBIST_WAIT));
        pulseTestDone(1'b0);
        checkOutput("lbist_start_pulse", int'(sif.bist_start), 1);
        checkOutput("lbist_BIST_mode", int'(sif.BIST_mode), 1);
        @(negedge clk);
        pulseTestDone(1'b0);
        checkOutput("sa_stays_lbist", int'(sif.phase), int'(LBIST_WAIT));
        pulseTestDone(1'b0);
        checkOutput("td_to_repair", int'(sif.phase), int'(REPAIR_WAIT));
        pulseTestDone(1'b0);
        checkOutput("repair_ignores_test_done", int'(sif.phase), int'(REPAIR_WAIT));
        checkOutput("repair_done_low", int'(sif.done), 0);
        pulseRecovery(1'b1);
        checkOutput("finish_done", int'(sif.done), 1);
        checkOutput("finish_busy", int'(sif.busy), 1);
        checkOutput("finish_test_mode", int'(sif.test_mode), 0);
        @(negedge clk);
        checkOutput("idle_done", int'(sif.done), 0);
        checkOutput("idle_busy", int'(sif.busy), 0);

        // Watchdog expiry in LBIST_WAIT.
        $display("[TB] watchdog expiry");
        exp_q.push_back('{ST_TIMEOUT, 1'b0, 1});
        pulseReq(1'b1);
        waitPhase(LBIST_WAIT, "to_reach_lbist");
        e = cycle;
        waitDone("to_done");
        checkOutput("timeout_latency", cycle - e, TO);
        @(negedge clk);

        // Events landing exactly on the expiry cycle win over the timeout.
        $display("[TB] events on expiry cycle");
        exp_q.push_back('{ST_PASS, 1'b0, 1});
        pulseReq(1'b1);
        waitPhase(LBIST_WAIT, "exp_reach_lbist");
        repeat (TO - 1) @(negedge clk);
        pulseTestDone(1'b0);
        checkOutput("exp_sa_wins", int'(sif.phase), int'(LBIST_WAIT));
        checkOutput("exp_sa_no_done", int'(sif.done), 0);
        repeat (TO - 1) @(negedge clk);
        pulseTestDone(1'b0);
        checkOutput("exp_td_wins", int'(sif.phase), int'(REPAIR_WAIT));
        repeat (TO - 1) @(negedge clk);
        pulseRecovery(1'b1);
        checkOutput("exp_recovery_wins", int'(sif.done), 1);
        @(negedge clk);

        // Reset while in REPAIR_WAIT: no done, everything back to reset values.
        $display("[TB] reset in REPAIR_WAIT");
        pulseReq(1'b1);
        waitPhase(LBIST_WAIT, "rr_reach_lbist");
        pulseTestDone(1'b0);
        pulseTd();
        pulseTestDone(1'b0);
        waitPhase(REPAIR_WAIT, "rr_reach_repair");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rr_busy", int'(sif.busy), 0);
        checkOutput("rr_done", int'(sif.done), 0);
        checkOutput("rr_test_mode", int'(sif.test_mode), 0);
        checkOutput("rr_BIST_mode", int'(sif.BIST_mode), 0);
        checkOutput("rr_td_seen", int'(sif.td_error_seen), 0);
        checkOutput("rr_status", int'(sif.status), 7);
        checkOutput("rr_phase", int'(sif.phase), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table of full runs, starting right after the mid-run reset.
        $display("[TB] table-driven runs");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/strait_selftest_scheduler.md
# strait_selftest_scheduler

Top-level self-test and self-recovery sequencer for the STRAIT accelerator. On one request it runs these phases in order: MBIST on the accumulator memory, LBIST (stuck-at, then transition-delay) on the systolic array, then BISR weight-allocation recovery. It drives `START`, `test_mode` and `BIST_mode` of the STRAIT core and watches that core's completion flags. It arms a per-phase watchdog and reports one final status code, so system firmware does not need to micro-manage the test flow.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum cycles allowed in any wait phase before it is aborted.
- `TIMEOUT_WIDTH`, default `$clog2(TIMEOUT_CYCLES+1)`: watchdog counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `selftest_req`  in  1  request pulse; ignored while `busy`.
- `skip_mbist`  in  1  sampled with an accepted request; 1 skips the MBIST phase.
- `bist_start`  out  1  one-cycle pulse to core `START`.
- `test_mode`  out  1  to core `test_mode`.
- `BIST_mode`  out  1  to core `BIST_mode` (0 MBIST, 1 LBIST).
- `test_done`  in  1  core phase-complete pulse.
- `MBIST_FAIL`  in  1  core MBIST result, valid with `test_done`.
- `TD_error_flag`  in  1  core transition-delay error flag.
- `recovery_done`  in  1  BISR completion pulse.
- `recovery_success`  in  1  BISR result, valid with `recovery_done`.
- `busy`  out  1  high from request acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `status`  out  3  final result code; held until the next accepted request.
- `td_error_seen`  out  1  sticky `TD_error_flag` capture for the current run.
- `phase`  out  3  current state encoding, for debug.

## Operation
States and transitions:
- IDLE → MBIST_START on `selftest_req`; goes to LBIST_START instead when `skip_mbist`=1.
- MBIST_START: one cycle, then MBIST_WAIT.
- MBIST_WAIT → LBIST_START on `test_done` with `MBIST_FAIL`=0.
- MBIST_WAIT → FINISH with status MBIST_FAIL on `test_done` with `MBIST_FAIL`=1.
- LBIST_START: one cycle, then LBIST_WAIT.
- LBIST_WAIT counts `test_done` pulses. Pulse 1 means SA complete and the scheduler stays in LBIST_WAIT. Pulse 2 means TD complete and the scheduler goes to REPAIR_WAIT.
- REPAIR_WAIT → FINISH on `recovery_done`. Status is PASS if `recovery_success`=1, otherwise UNREPAIRABLE.
- FINISH: one cycle, then IDLE.

Output behaviour:
- `bist_start` is high only in MBIST_START and LBIST_START.
- `test_mode` is high from MBIST_START (or LBIST_START) through REPAIR_WAIT inclusive, and low in FINISH and IDLE.
- `BIST_mode` is 0 in MBIST states and 1 from LBIST_START through REPAIR_WAIT.
- `td_error_seen` sets on any cycle of LBIST_WAIT with `TD_error_flag`=1. It clears when a request is accepted.

Status codes: 0 PASS, 1 UNREPAIRABLE, 2 MBIST_FAIL, 3 TIMEOUT, 7 NONE (reset value).

Watchdog:
- Cleared on entry to every WAIT state, and also on the first `test_done` in LBIST_WAIT.
- Increments once per WAIT cycle.
- At count `TIMEOUT_CYCLES-1` with no qualifying event, the scheduler goes to FINISH with status TIMEOUT.

## Timing
- Reset values: state IDLE, all single-bit outputs 0, `status`=7, `phase`=0, watchdog 0. Reset mid-run returns to IDLE immediately; no `done` pulse is issued.
- Request latency: `selftest_req` at cycle N causes `bist_start` at N+1. `busy` is high from N+1.
- Completion latency: an event in a WAIT state at cycle M causes FINISH, `done` and the `status` update at M+1. `busy` is low from M+2.
- Simultaneous events:
  - An event and watchdog expiry in the same cycle: the event wins.
  - `test_done` during a START cycle is ignored.
  - `selftest_req` during `busy` or FINISH is dropped.
  - `test_done` in REPAIR_WAIT is ignored.
  - `recovery_done` outside REPAIR_WAIT is ignored.

## Structure
- Shared package `strait_pkg`:
  - state enum `sched_state_t` with codes IDLE=0, MBIST_START=1, MBIST_WAIT=2, LBIST_START=3, LBIST_WAIT=4, REPAIR_WAIT=5, FINISH=6;
  - status constants `ST_PASS`, `ST_UNREPAIRABLE`, `ST_MBIST_FAIL`, `ST_TIMEOUT`, `ST_NONE`.
- One sub-module, `strait_phase_timer`: clear/enable watchdog counter with an `expired` output.

## Test plan
- Happy path: request at cycle 10, `skip_mbist`=0. Core returns `test_done` (`MBIST_FAIL`=0), then two LBIST `test_done` pulses, then `recovery_done` with `recovery_success`=1. Expect `bist_start` at cycles 11 and the LBIST_START cycle, one `done` pulse, `status`=0, `td_error_seen`=0.
- MBIST fail: `test_done` with `MBIST_FAIL`=1 in MBIST_WAIT. Expect `done` the next cycle, `status`=2, no second `bist_start`, `test_mode`=0 after FINISH.
- LBIST with TD error and unrepairable array: `TD_error_flag` pulsed between the SA and TD `test_done` pulses, then `recovery_done` with `recovery_success`=0. Expect `td_error_seen`=1 and `status`=1.
- Watchdog: `TIMEOUT_CYCLES`=16, `skip_mbist`=1, core never answers. Expect `done` exactly 16 cycles after LBIST_WAIT entry and `status`=3. A second case puts `test_done` on the expiry cycle and expects no timeout.
- Robustness:
  - `selftest_req` pulsed while `busy`: ignored.
  - `rst` asserted in REPAIR_WAIT: all outputs reset the next cycle, `status`=7.
  - A new request after reset completes normally.
